// File: rtl/sram_arb_pkg.sv
// Shared encodings and width helpers for the SRAM-like arbiter.
// Grant policy is selected with SRAM_ARB_RR_EN (round-robin) or left undefined (fixed priority).
package sram_arb_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // Channel IDs need at least one bit even when a single ID would fit in zero.
  function automatic int id_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int ptr_width(int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/sram_arb_idfifo.sv
// In-order channel-ID FIFO: remembers which master issued each accepted transaction.
// Simultaneous push and pop are legal; pointers wrap modulo DEPTH.
module sram_arb_idfifo #(
  parameter int DEPTH = 4,
  parameter int W     = 1,
  parameter int PW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  head,
  output logic [PW:0]   count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) begin
      rd_d = rd_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_q];
  assign count = cnt_q;

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel SRAM-like arbiter onto one slave port with in-order response routing.
// Define SRAM_ARB_RR_EN for round-robin grant; otherwise lowest index wins.
module sram_like_arbiter #(
  parameter int N_CH  = 2,
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_CH-1:0]           m_req,
  input  logic [N_CH-1:0]           m_wr,
  input  logic [2*N_CH-1:0]         m_size,
  input  logic [(DW/8)*N_CH-1:0]    m_wstrb,
  input  logic [AW*N_CH-1:0]        m_addr,
  input  logic [DW*N_CH-1:0]        m_wdata,
  output logic [N_CH-1:0]           m_addr_ok,
  output logic [N_CH-1:0]           m_data_ok,
  output logic [DW-1:0]             m_rdata,
  output logic                      s_req,
  output logic                      s_wr,
  output logic [1:0]                s_size,
  output logic [DW/8-1:0]           s_wstrb,
  output logic [AW-1:0]             s_addr,
  output logic [DW-1:0]             s_wdata,
  input  logic                      s_addr_ok,
  input  logic                      s_data_ok,
  input  logic [DW-1:0]             s_rdata,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      err
);
  import sram_arb_pkg::*;

  localparam int IW = id_width(N_CH);
  localparam int PW = ptr_width(DEPTH);
  localparam int WB = DW / 8;

  logic [IW-1:0] g, g_arb, head, lock_id_q, lock_id_d;
  logic          locked_q, locked_d, err_q, err_d;
  logic          full, hs, pop;
  logic [PW:0]   count;

  assign full = (count == (PW+1)'(DEPTH));

`ifdef SRAM_ARB_RR_EN
  logic [IW-1:0] rr_q, rr_d;

  // Pick the requester closest to rr_q going upward with wrap.
  always_comb begin
    int best;
    int dist;
    best  = N_CH;
    dist  = 0;
    g_arb = '0;
    for (int i = 0; i < N_CH; i++) begin
      dist = i - int'(rr_q);
      if (dist < 0) dist = dist + N_CH;
      if (m_req[i] && dist < best) begin
        best  = dist;
        g_arb = IW'(i);
      end
    end
    rr_d = rr_q;
    if (hs) rr_d = (g == IW'(N_CH-1)) ? '0 : g + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= '0;
    else       rr_q <= rr_d;
  end
`else
  always_comb begin
    g_arb = '0;
    for (int i = N_CH-1; i >= 0; i--) begin
      if (m_req[i]) g_arb = IW'(i);
    end
  end
`endif

  assign g = locked_q ? lock_id_q : g_arb;

  // Lock FSM: state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      locked_q  <= 1'b0;
      lock_id_q <= '0;
      err_q     <= 1'b0;
    end else begin
      locked_q  <= locked_d;
      lock_id_q <= lock_id_d;
      err_q     <= err_d;
    end
  end

  // Lock FSM: next state. A pending unaccepted request freezes the grant.
  always_comb begin
    locked_d  = locked_q;
    lock_id_d = lock_id_q;
    err_d     = err_q | (s_data_ok & (count == '0));
    if (hs) begin
      locked_d = 1'b0;
    end else if (s_req && !locked_q) begin
      locked_d  = 1'b1;
      lock_id_d = g;
    end
  end

  // Lock FSM: outputs and muxing.
  always_comb begin
    s_req     = (|m_req | locked_q) & ~full & ~reset;
    hs        = s_req & s_addr_ok;
    pop       = s_data_ok & (count != '0) & ~reset;
    s_wr      = 1'b0;
    s_size    = SIZE_BYTE;
    s_wstrb   = '0;
    s_addr    = '0;
    s_wdata   = '0;
    m_addr_ok = '0;
    m_data_ok = '0;
    m_rdata   = reset ? '0 : s_rdata;
    for (int i = 0; i < N_CH; i++) begin
      if (!reset && g == IW'(i)) begin
        s_wr    = m_wr[i];
        s_size  = m_size[2*i +: 2];
        s_wstrb = m_wstrb[WB*i +: WB];
        s_addr  = m_addr[AW*i +: AW];
        s_wdata = m_wdata[DW*i +: DW];
      end
      if (hs && g == IW'(i))     m_addr_ok[i] = 1'b1;
      if (pop && head == IW'(i)) m_data_ok[i] = 1'b1;
    end
  end

  sram_arb_idfifo #(
    .DEPTH (DEPTH),
    .W     (IW),
    .PW    (PW)
  ) u_idfifo (
    .clk   (clk),
    .reset (reset),
    .push  (hs),
    .pop   (pop),
    .din   (g),
    .head  (head),
    .count (count)
  );

  assign outstanding = count;
  assign err         = err_q;

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Parametrised N-channel arbiter merging several SRAM-like master ports (req/addr_ok/data_ok, in-order responses) onto one SRAM-like slave port. It generalises the CPU's fixed inst/data split: the instruction fetch, the data access and future masters share a single memory bridge. Up to DEPTH transactions may be outstanding. A channel-ID FIFO routes each data_ok/rdata back to the issuing master.

## Interface
Parameters:
- N_CH, 2, number of master channels (≥2); index 0 = data, 1 = inst by convention
- DEPTH, 4, max outstanding accepted transactions (power of two, ≥2)
- AW, 32, address width
- DW, 32, data width (DW/8 strobe bits)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- m_req  in  N_CH  per-channel request
- m_wr  in  N_CH  per-channel write flag
- m_size  in  2*N_CH  per-channel size (0 byte, 1 half, 2 word)
- m_wstrb  in  (DW/8)*N_CH  per-channel byte strobes
- m_addr  in  AW*N_CH  per-channel address
- m_wdata  in  DW*N_CH  per-channel write data
- m_addr_ok  out  N_CH  per-channel address accept
- m_data_ok  out  N_CH  per-channel response valid
- m_rdata  out  DW  read data, broadcast to all channels
- s_req, s_wr  out  1  slave request / write flag
- s_size  out  2; s_wstrb  out  DW/8; s_addr  out  AW; s_wdata  out  DW
- s_addr_ok, s_data_ok  in  1  slave accept / response
- s_rdata  in  DW  slave read data
- outstanding  out  clog2(DEPTH)+1  accepted-but-unanswered count
- err  out  1  sticky: data_ok received with no outstanding transaction

## Operation
- Masters hold req and all request fields stable from assertion until their addr_ok. The slave returns data_ok strictly in acceptance order, one per accepted transaction (reads and writes).
- full = (outstanding == DEPTH), registered. s_req = (any m_req | locked) & ~full.
- Grant g: if locked, g = lock_id. Otherwise g is chosen among asserted m_req by the arbitration policy (see Configuration). The s_* fields mux from channel g.
- m_addr_ok[i] = s_req & s_addr_ok & (g == i). All other channels see 0.
- Lock: s_req & ~s_addr_ok with not locked sets locked=1 and lock_id=g. The handshake (s_req & s_addr_ok) clears locked. Slave-visible fields never change while s_req is pending.
- Push: on a handshake, g is pushed into the ID FIFO.
- Pop: on s_data_ok with outstanding>0, head is popped. m_data_ok[head] = 1. m_rdata = s_rdata (pass-through, all channels).
- Simultaneous push and pop: outstanding is unchanged and both pointers advance. A pop in the same cycle as full does not enable a push that cycle (full is registered).
- FIFO pointers are clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- s_data_ok with outstanding==0: ignored, no m_data_ok, err set (cleared only by reset).

## Timing
- Zero added latency: request, addr_ok, data_ok and rdata paths are combinational through the grant/head muxes.
- State updates on the clk edge after the handshake: outstanding, pointers, lock, rr pointer.
- Reset values: locked=0, lock_id=0, rr_ptr=0, FIFO empty, outstanding=0, err=0. All outputs are 0 while reset is high (s_req=0, m_addr_ok=0, m_data_ok=0).
- Reset mid-transaction drops all outstanding IDs. Responses still in flight from the slave after reset count as spurious (err=1). The system reset covers the slave as well.

## Configuration
- SRAM_ARB_RR_EN defined: round-robin. rr_ptr advances to (g+1) mod N_CH on each handshake. The search starts at rr_ptr.
- Undefined: fixed priority, lowest index wins. rr_ptr logic is compiled out.

## Structure
- Package sram_arb_pkg: size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD and the clog2-based width constants.
- Sub-module sram_arb_idfifo: DEPTH-entry, clog2(N_CH)-bit-wide synchronous FIFO with push/pop/head/count. Simultaneous push and pop are legal.

## Test plan
- Single channel: ch1 req, addr 0x1c000000, s_addr_ok after 3 cycles → s_addr stable throughout, m_addr_ok[1] pulses once; s_data_ok with s_rdata 0x12345678 → m_data_ok[1]=1, m_rdata=0x12345678.
- Contention, RR build: ch0 and ch1 request continuously, slave accepts every cycle → grants alternate 0,1,0,1. Fixed-priority build: ch0 only while it requests.
- Depth: DEPTH=4, 4 accepts without data_ok → outstanding=4, s_req=0 despite m_req. One data_ok → outstanding=3, s_req=1 the next cycle.
- Ordering: accept ch1, ch0, ch1 → three data_ok route to ch1, ch0, ch1 in order. Push and pop in the same cycle keep outstanding constant.
- Spurious data_ok with outstanding=0 → no m_data_ok, err=1 and sticky until reset.
- Reset asserted with 2 outstanding and locked=1 → next cycle outstanding=0, locked=0, all outputs 0.
